// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared registered ALU.
// One operation in flight at a time: accept, issue, wait for the result, hold the response.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             iClk,
    input  logic             iRstN,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_rs1,
    input  logic [WIDTH-1:0] req0_rs2,
    input  logic [31:0]      req0_instr,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_rs1,
    input  logic [WIDTH-1:0] req1_rs2,
    input  logic [31:0]      req1_instr,

    output logic [WIDTH-1:0] alu_rs1,
    output logic [WIDTH-1:0] alu_rs2,
    output logic [11:0]      alu_imm,
    output logic [6:0]       alu_opcode,
    output logic [2:0]       alu_funct3,
    output logic [6:0]       alu_funct7,
    output logic [4:0]       alu_shamt,
    input  logic [WIDTH-1:0] alu_rd,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    localparam logic [6:0] OpcR = 7'b0110011;
    localparam logic [6:0] OpcI = 7'b0010011;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] rs1_q, rs1_d;
    logic [WIDTH-1:0] rs2_q, rs2_d;
    logic [31:0]      instr_q, instr_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic grant_id;
    logic accept;
    logic legal;
    logic alu_active;
    logic unused_instr_bits;

    // Round-robin only matters under contention; a lone requester always wins.
    always_comb begin
        grant_id = req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end
        accept = iRstN && (state_q == StIdle) && (req0_valid || req1_valid);
    end

    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept & grant_id;

    assign legal = (instr_q[6:0] == OpcR) || (instr_q[6:0] == OpcI);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        instr_d      = instr_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    rs1_d        = grant_id ? req1_rs1 : req0_rs1;
                    rs2_d        = grant_id ? req1_rs2 : req0_rs2;
                    instr_d      = grant_id ? req1_instr : req0_instr;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (legal) begin
                    state_d = StWait;
                end else begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end
            end
            StWait: begin
                rsp_data_d = alu_rd;
                rsp_err_d  = 1'b0;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            instr_q      <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            instr_q      <= instr_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Illegal ops never present their opcode, so the ALU stays idle with RD at 0.
    assign alu_active = (state_q == StIssue) || (state_q == StWait);
    assign alu_rs1    = alu_active ? rs1_q : '0;
    assign alu_rs2    = alu_active ? rs2_q : '0;
    assign alu_imm    = alu_active ? instr_q[31:20] : '0;
    assign alu_opcode = (alu_active && legal) ? instr_q[6:0] : '0;
    assign alu_funct3 = alu_active ? instr_q[14:12] : '0;
    assign alu_funct7 = alu_active ? instr_q[31:25] : '0;
    assign alu_shamt  = alu_active ? instr_q[24:20] : '0;

    assign rsp_valid = (state_q == StResp);
    assign rsp_id    = owner_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != StIdle);

    // Register-address fields are carried with the instruction but not needed here.
    assign unused_instr_bits = ^{instr_q[19:15], instr_q[11:7]};

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed and random ops against a transaction-level model,
// with a behavioural registered ALU standing in for the shared unit.
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam logic [6:0] OpcR = 7'b0110011;
    localparam logic [6:0] OpcI = 7'b0010011;

    logic             iClk;
    logic             iRstN;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_rs1, req0_rs2;
    logic [31:0]      req0_instr;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_rs1, req1_rs2;
    logic [31:0]      req1_instr;
    logic [WIDTH-1:0] alu_rs1, alu_rs2;
    logic [11:0]      alu_imm;
    logic [6:0]       alu_opcode;
    logic [2:0]       alu_funct3;
    logic [6:0]       alu_funct7;
    logic [4:0]       alu_shamt;
    logic [WIDTH-1:0] alu_rd;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [WIDTH-1:0] rsp_data;

    int   total;
    int   bad;
    logic lg;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .iClk       (iClk),
        .iRstN      (iRstN),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_rs1   (req0_rs1),
        .req0_rs2   (req0_rs2),
        .req0_instr (req0_instr),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_rs1   (req1_rs1),
        .req1_rs2   (req1_rs2),
        .req1_instr (req1_instr),
        .alu_rs1    (alu_rs1),
        .alu_rs2    (alu_rs2),
        .alu_imm    (alu_imm),
        .alu_opcode (alu_opcode),
        .alu_funct3 (alu_funct3),
        .alu_funct7 (alu_funct7),
        .alu_shamt  (alu_shamt),
        .alu_rd     (alu_rd),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Expected {err, data} of an instruction, straight from the ISA meaning.
    function automatic logic [32:0] ref_result(input logic [31:0] instr,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [31:0] op_b;
        logic        is_r, is_i;
        is_r = (instr[6:0] == OpcR);
        is_i = (instr[6:0] == OpcI);
        if (!is_r && !is_i) return {1'b1, 32'd0};
        op_b = is_r ? b : {{20{instr[31]}}, instr[31:20]};
        case (instr[14:12])
            3'b000:  return {1'b0, (is_r && instr[31:25] == 7'b0100000) ? a - op_b : a + op_b};
            3'b100:  return {1'b0, a ^ op_b};
            3'b110:  return {1'b0, a | op_b};
            3'b111:  return {1'b0, a & op_b};
            default: return {1'b0, 32'd0};
        endcase
    endfunction

    function automatic logic [31:0] alu_model(input logic [6:0] opc, input logic [2:0] f3,
                                              input logic [11:0] imm,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [32:0] t;
        t = ref_result({imm, 5'd0, f3, 5'd0, opc}, a, b);
        return t[32] ? 32'd0 : t[31:0];
    endfunction

    always @(posedge iClk) begin
        alu_rd <= alu_model(alu_opcode, alu_funct3, alu_imm, alu_rs1, alu_rs2);
    end

    function automatic logic [31:0] make_instr(input int kind, input logic [31:0] rnd);
        logic [31:0] x;
        x = rnd;
        case (kind)
            0: begin x[31:25] = 7'b0000000; x[14:12] = 3'b000; x[6:0] = OpcR; end
            1: begin x[31:25] = 7'b0100000; x[14:12] = 3'b000; x[6:0] = OpcR; end
            2: begin x[31:25] = 7'b0000000; x[14:12] = 3'b111; x[6:0] = OpcR; end
            3: begin x[31:25] = 7'b0000000; x[14:12] = 3'b110; x[6:0] = OpcR; end
            4: begin x[31:25] = 7'b0000000; x[14:12] = 3'b100; x[6:0] = OpcR; end
            5: begin x[14:12] = 3'b000; x[6:0] = OpcI; end
            6: begin x[14:12] = rnd[12] ? 3'b111 : 3'b100; x[6:0] = OpcI; end
            default: x[6:0] = rnd[3] ? 7'b1100011 : 7'b0000011;
        endcase
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester-side noise while the block is busy; none of it may reach the in-flight op.
    task automatic scramble();
        req0_valid = 1'($urandom_range(0, 1));
        req1_valid = 1'($urandom_range(0, 1));
        req0_rs1   = $urandom;
        req0_rs2   = $urandom;
        req0_instr = $urandom;
        req1_rs1   = $urandom;
        req1_rs2   = $urandom;
        req1_instr = $urandom;
    endtask

    task automatic run_op(input logic v0, input logic v1,
                          input logic [31:0] a0, b0, i0, a1, b1, i1, input int stall);
        logic        gid, leg;
        logic [31:0] a, b, i;
        logic [32:0] r;
        @(negedge iClk);
        req0_valid = v0; req0_rs1 = a0; req0_rs2 = b0; req0_instr = i0;
        req1_valid = v1; req1_rs1 = a1; req1_rs2 = b1; req1_instr = i1;
        rsp_ready  = 1'b0;
        gid = (v0 && v1) ? ~lg : v1;
        lg  = gid;
        a = gid ? a1 : a0;
        b = gid ? b1 : b0;
        i = gid ? i1 : i0;
        leg = (i[6:0] == OpcR) || (i[6:0] == OpcI);
        r = ref_result(i, a, b);
        #1;
        check("accept_ready0", 32'(req0_ready), 32'(!gid));
        check("accept_ready1", 32'(req1_ready), 32'(gid));

        @(negedge iClk);
        scramble();
        #1;
        check("issue_busy", 32'(busy), 1);
        check("issue_ready", 32'({req0_ready, req1_ready}), 0);
        check("issue_rsp_valid", 32'(rsp_valid), 0);
        check("issue_rs1", alu_rs1, a);
        check("issue_rs2", alu_rs2, b);
        check("issue_imm", 32'(alu_imm), 32'(i[31:20]));
        check("issue_opcode", 32'(alu_opcode), leg ? 32'(i[6:0]) : 0);
        check("issue_funct3", 32'(alu_funct3), 32'(i[14:12]));
        check("issue_funct7", 32'(alu_funct7), 32'(i[31:25]));
        check("issue_shamt", 32'(alu_shamt), 32'(i[24:20]));

        if (leg) begin
            @(negedge iClk);
            scramble();
            #1;
            check("wait_rsp_valid", 32'(rsp_valid), 0);
            check("wait_rs1", alu_rs1, a);
            check("wait_imm", 32'(alu_imm), 32'(i[31:20]));
            check("wait_opcode", 32'(alu_opcode), 32'(i[6:0]));
        end

        @(negedge iClk);
        scramble();
        rsp_ready = (stall == 0);
        #1;
        check("resp_valid", 32'(rsp_valid), 1);
        check("resp_id", 32'(rsp_id), 32'(gid));
        check("resp_data", rsp_data, r[31:0]);
        check("resp_err", 32'(rsp_err), 32'(r[32]));
        check("resp_alu_opcode", 32'(alu_opcode), 0);
        check("resp_alu_rs1", alu_rs1, 0);
        check("resp_ready", 32'({req0_ready, req1_ready}), 0);

        for (int s = 1; s <= stall; s++) begin
            @(negedge iClk);
            scramble();
            if (s == stall) rsp_ready = 1'b1;
            #1;
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_data", rsp_data, r[31:0]);
            check("hold_id", 32'(rsp_id), 32'(gid));
            check("hold_ready", 32'({req0_ready, req1_ready}), 0);
        end

        @(negedge iClk);
        rsp_ready  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("done_rsp_valid", 32'(rsp_valid), 0);
        check("done_busy", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] add_i, sub_i, addi_i, bad_i;
        total = 0;
        bad   = 0;
        add_i  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, OpcR};
        sub_i  = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, OpcR};
        addi_i = {12'h00F, 5'd1, 3'b000, 5'd2, OpcI};
        bad_i  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};

        // Reset with both requesters pushing: nothing may be granted.
        iRstN = 1'b0;
        rsp_ready = 1'b0;
        scramble();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) begin
            @(negedge iClk);
            #1;
            check("rst_ready0", 32'(req0_ready), 0);
            check("rst_ready1", 32'(req1_ready), 0);
        end
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_alu_opcode", 32'(alu_opcode), 0);
        check("rst_alu_rs1", alu_rs1, 0);
        check("rst_alu_imm", 32'(alu_imm), 0);
        @(negedge iClk);
        iRstN = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lg = 1'b1;

        // Contention straight out of reset: grants go 0,1,0,1.
        repeat (4) run_op(1'b1, 1'b1, 1, 1, add_i, 1, 1, add_i, 0);

        run_op(1'b1, 1'b0, 5, 7, add_i, 0, 0, 0, 0);
        run_op(1'b1, 1'b0, 10, 3, sub_i, 0, 0, 0, 5);
        run_op(1'b0, 1'b1, 0, 0, 0, 9, 4, bad_i, 0);
        run_op(1'b1, 1'b0, 32'h10, 0, addi_i, 0, 0, 0, 1);

        // Reset while the op waits on the ALU: it must vanish without a response.
        @(negedge iClk);
        req0_valid = 1'b1; req0_rs1 = 3; req0_rs2 = 4; req0_instr = add_i;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        #1;
        check("rw_accept", 32'(req0_ready), 1);
        @(negedge iClk);
        req0_valid = 1'b0;
        #1;
        check("rw_issue_busy", 32'(busy), 1);
        @(negedge iClk);
        #1;
        check("rw_wait_opcode", 32'(alu_opcode), 32'(OpcR));
        iRstN = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge iClk);
        #1;
        check("rw_busy", 32'(busy), 0);
        check("rw_rsp_valid", 32'(rsp_valid), 0);
        check("rw_alu_opcode", 32'(alu_opcode), 0);
        check("rw_ready", 32'({req0_ready, req1_ready}), 0);
        iRstN = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lg = 1'b1;
        repeat (3) begin
            @(negedge iClk);
            #1;
            check("rw_no_rsp", 32'(rsp_valid), 0);
        end
        rsp_ready = 1'b0;
        run_op(1'b1, 1'b1, 2, 2, add_i, 6, 6, sub_i, 0);

        for (int n = 0; n < 40; n++) begin
            logic        v0, v1;
            logic [31:0] i0, i1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            i0 = make_instr(int'($urandom_range(0, 7)), $urandom);
            i1 = make_instr(int'($urandom_range(0, 7)), $urandom);
            run_op(v0, v1, $urandom, $urandom, i0, $urandom, $urandom, i1,
                   int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width of operands and result.
REQ-002 iClk  input  1  single clock; all state updates on rising edge.
REQ-003 iRstN  input  1  reset, synchronous, active-low.
REQ-004 reqN_valid (N=0,1)  input  1  requester N presents an operation.
REQ-005 reqN_ready (N=0,1)  output  1  accept strobe; transfer occurs when reqN_valid && reqN_ready.
REQ-006 reqN_rs1, reqN_rs2  input  WIDTH  signed operands of requester N.
REQ-007 reqN_instr  input  32  RISC-V instruction word of requester N.
REQ-008 alu_rs1, alu_rs2  output  WIDTH  operands to the shared registered ALU.
REQ-009 alu_imm  output  12  I-type immediate, instr[31:20].
REQ-010 alu_opcode/alu_funct3/alu_funct7/alu_shamt  output  7/3/7/5  instr[6:0]/[14:12]/[31:25]/[24:20].
REQ-011 alu_rd  input  WIDTH  ALU result, valid one clock after operands and opcode are presented.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_id  output  1  requester that owns the response.
REQ-015 rsp_data  output  WIDTH  captured result.
REQ-016 rsp_err  output  1  opcode was neither 0110011 (R) nor 0010011 (I).
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one active.
REQ-019 IDLE: if either reqN_valid is high, grant one requester, assert only its reqN_ready for that cycle, latch its rs1, rs2, and instr, then go to ISSUE. Otherwise stay in IDLE.
REQ-020 reqN_ready is combinational from state, valids, and pointer; it is high only in IDLE.
REQ-021 Round-robin arbitration:
- last_grant pointer, reset value 1, so req0 wins the first contention.
- Both valid: grant !last_grant.
- One valid: grant it.
- last_grant updates to the granted id on every accept.
REQ-022 ISSUE lasts 1 cycle:
- Drive latched fields on alu_* outputs.
- Legal opcode: go to WAIT.
- Illegal opcode: skip WAIT, load rsp_data=0 and rsp_err=1, go to RESP.
REQ-023 WAIT lasts 1 cycle:
- alu_* outputs are held at the latched values.
- Capture alu_rd into rsp_data, set rsp_err=0, go to RESP.
REQ-024 Outside ISSUE/WAIT, all alu_* outputs are 0, so alu_opcode=0 and the ALU holds RD at 0.
REQ-025 RESP:
- rsp_valid=1; rsp_id, rsp_data, and rsp_err are stable.
- On rsp_ready=1: go to IDLE, rsp_valid drops the next cycle.
- On rsp_ready=0: hold indefinitely.
REQ-026 Latency for a legal op accepted at edge E: rsp_valid first high in the cycle after edge E+3. Throughput is one op per 4 cycles minimum.
REQ-027 Illegal op latency: rsp_valid first high in the cycle after edge E+2.
REQ-028 New requests are never accepted while busy. A requester deasserting valid before grant loses nothing.
REQ-029 Operands and instr are sampled only at accept; later changes on reqN_* do not affect the in-flight op.
REQ-030 No arithmetic in this block: results pass through unmodified at WIDTH bits. Immediate and shamt are bit-slices only, with no extension.

Reset
REQ-031 iRstN=0 at a rising edge forces, regardless of state:
- state=IDLE, last_grant=1.
- rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
- All latched fields=0, so all alu_* outputs=0.
REQ-032 reqN_ready=0 while iRstN=0.
REQ-033 Reset mid-operation (ISSUE/WAIT/RESP) discards the op with no response. The first accept after release follows REQ-021 with last_grant=1.

Verification
REQ-034 Single legal op:
- Stimulus: req0 valid, instr=ADD R-type (opcode 0110011, funct3 000, funct7 0), rs1=5, rs2=7, rsp_ready=1.
- Required response: rsp_valid 3 cycles after accept, rsp_id=0, rsp_data=12, rsp_err=0.
REQ-035 Contention:
- Stimulus: both valid continuously, rs1=1/rs2=1 on both.
- Required response: grants alternate 0,1,0,1 from reset; each rsp_id matches grant order.
REQ-036 Back-pressure:
- Stimulus: SUB (funct7 0100000) 10-3, rsp_ready=0 for 5 cycles.
- Required response: rsp_valid held with rsp_data=7; req1_ready stays 0 throughout; release on rsp_ready=1.
REQ-037 Illegal opcode:
- Stimulus: opcode 1100011 from req1.
- Required response: rsp_err=1, rsp_data=0, rsp_valid 2 cycles after accept, alu_opcode stays 0.
REQ-038 Immediate:
- Stimulus: ADDI, instr[31:20]=0x00F, rs1=0x10.
- Required response: alu_imm=0x00F in ISSUE, rsp_data=0x1F.
REQ-039 Reset in WAIT:
- Stimulus: assert iRstN=0 for one edge while in WAIT.
- Required response: no rsp_valid, busy=0, next contention granted to req0.
